// File: rtl/audio_sdm_dac_mc.sv
// rtl/audio_sdm_dac_mc.sv - multichannel first-order delta-sigma audio DAC fed from a frame FIFO
// Optional build macro AUDIO_DITHER_EN: 16-bit LFSR dither on the accumulator carry-in.
module audio_sdm_dac_mc #(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 256,
    parameter int RATE_DIV   = 256
) (
    input  logic                              sys_clock,
    input  logic                              reset_,
    input  logic                              enable,
    input  logic [CHANNELS*SAMPLE_W-1:0]      in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              sample_tick,
    output logic                              underflow,
    input  logic                              clr_underflow,
    output logic [CHANNELS-1:0]               audio_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(RATE_DIV);
    localparam int FW = CHANNELS * SAMPLE_W;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATE_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    logic [FW-1:0]                     mem_q [FIFO_DEPTH];
    logic [AW-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                     level_q, level_d;
    logic                              full_q, full_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic                              underflow_q, underflow_d;
    logic [FW-1:0]                     cur_q, cur_d;
    logic [CHANNELS-1:0][SAMPLE_W-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0]               audio_q, carry_d;
    logic                              push, pop, tick, empty, cin;

    assign push  = in_valid && !full_q;
    assign tick  = enable && (cnt_q == CNT_LAST);
    assign empty = (level_q == '0);
    assign pop   = tick && !empty;

    assign in_ready    = !full_q;
    assign fifo_full   = full_q;
    assign fifo_level  = level_q;
    assign sample_tick = tick;
    assign underflow   = underflow_q;
    assign audio_out   = audio_q;

`ifdef AUDIO_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cin    = lfsr_q[0];

    // Free-running dither source, restarts from its seed on every reset
    always_ff @(posedge sys_clock or negedge reset_) begin
        if (!reset_) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end
`else
    assign cin = 1'b0;
`endif

    // Per-channel modulator: offset-binary sample added into a wrapping accumulator, carry is the bit
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SAMPLE_W-1:0] u;
        logic [SAMPLE_W:0]   sum;
        assign u          = cur_q[c*SAMPLE_W +: SAMPLE_W] ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
        assign sum        = {1'b0, acc_q[c]} + {1'b0, u} + {{SAMPLE_W{1'b0}}, cin};
        assign acc_d[c]   = sum[SAMPLE_W-1:0];
        assign carry_d[c] = sum[SAMPLE_W];
    end

    // Next-state for FIFO bookkeeping, sample-period counter, current samples and underflow flag
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d     = level_q + LW'(push) - LW'(pop);
        full_d      = (level_d == LVL_FULL);
        cnt_d       = '0;
        if (enable && cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        cur_d       = cur_q;
        if (!enable)  cur_d = '0;
        else if (pop) cur_d = mem_q[rd_ptr_q];
        underflow_d = underflow_q;
        if (tick && empty)      underflow_d = 1'b1;
        else if (clr_underflow) underflow_d = 1'b0;
    end

    // Frame storage; stale entries are harmless because the level gates every read
    always_ff @(posedge sys_clock) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // Control and modulator state, all cleared asynchronously
    always_ff @(posedge sys_clock or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
            cur_q       <= '0;
            acc_q       <= '0;
            audio_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
            cur_q       <= cur_d;
            acc_q       <= acc_d;
            audio_q     <= carry_d;
        end
    end
endmodule
